pc_sequencer: RTL and testbench

Registered program-counter sequencer for the single-cycle core. It owns the PC register, selects the next PC among sequential increment, branch, jump, call and return targets, and supports stall and halt/resume. It sits between the control decoder and instruction memory, and replaces the free-running PC+1 path as the source of the fetch address. A small return-address stack lets the core support call/return without using general registers.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 45 ++++
 rtl/pc_return_stack.sv | 74 +++++++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq_pkg
//  Purpose  : Shared types and constants for the program-counter sequencer.
//             - seq_state_t : sequencer control states (BOOT / RUN / HALTED)
//             - pc_sel_t    : next-PC source select
//             - default PC width and reset PC
//  Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int unsigned c_default_width    = 32;
    localparam logic [31:0] c_default_reset_pc = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_SEQ    = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_CALL   = 3'd4,
        SEL_RET    = 3'd5
    } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Control/fetch bundle between the control decoder and the PC
//             sequencer.
//  Signals  : stall, halt_req, resume, branch_taken, branch_target, jump,
//             call, jump_target, ret          (decoder -> sequencer)
//             pc, pc_plus1, fetch_valid, halted,
//             ras_overflow, ras_underflow     (sequencer -> decoder/fetch)
//  Modports : master = decoder side, slave = sequencer side
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int WIDTH = pc_seq_pkg::c_default_width
);
    logic             stall;
    logic             halt_req;
    logic             resume;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic             call;
    logic [WIDTH-1:0] jump_target;
    logic             ret;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic             fetch_valid;
    logic             halted;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output stall, halt_req, resume, branch_taken, branch_target,
               jump, call, jump_target, ret,
        input  pc, pc_plus1, fetch_valid, halted, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, halt_req, resume, branch_taken, branch_target,
               jump, call, jump_target, ret,
        output pc, pc_plus1, fetch_valid, halted, ras_overflow, ras_underflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
//  Module   : pc_return_stack
//  Purpose  : Circular return-address stack with a top pointer and a
//             saturating entry count. A push to a full stack overwrites the
//             oldest entry; a pop from an empty stack changes nothing.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             push, pop     - stack operations (push+pop replaces the top)
//             push_data     - value to push
//             top           - current top-of-stack value
//             empty, full   - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module pc_return_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] push_data,
    output      logic [WIDTH-1:0] top,
    output      logic             empty,
    output      logic             full
);
    localparam int              c_ptr_w = $clog2(RAS_DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0]   r_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_top;
    logic [c_ptr_w:0]   r_count;
    logic [c_ptr_w-1:0] w_top_inc;

    // Depth is a power of two, so the pointer wraps naturally. Once the
    // buffer is full, the slot after the top is the oldest entry, which is
    // exactly where the next push lands.
    assign w_top_inc = r_top + c_ptr_w'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (push && pop) begin
            r_top   <= r_top;
            r_count <= r_count;
        end else if (push) begin
            r_top <= w_top_inc;
            if (r_count != c_depth) begin
                r_count <= r_count + (c_ptr_w + 1)'(1);
            end
        end else if (pop && (r_count != '0)) begin
            r_top   <= r_top - c_ptr_w'(1);
            r_count <= r_count - (c_ptr_w + 1)'(1);
        end
    end

    // Storage carries no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            if (pop) begin
                r_mem[r_top] <= push_data;
            end else begin
                r_mem[w_top_inc] <= push_data;
            end
        end
    end

    assign top   = r_mem[r_top];
    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Registered program counter with prioritised next-PC select
//             (stall > halt > ret > call > jump > branch > sequential),
//             BOOT/RUN/HALTED control and a return-address stack.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             bus (slave)   - decoder controls in; pc, pc_plus1,
//                             fetch_valid, halted, ras_overflow,
//                             ras_underflow out
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH     = c_default_width,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(c_default_reset_pc),
    parameter int               RAS_DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    pc_sequencer_if.slave bus
);
    seq_state_t       r_state;
    seq_state_t       w_state_next;
    pc_sel_t          w_sel;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus1;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf;
    logic             w_unf;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;
    logic             w_ras_full;

    assign w_pc_plus1 = r_pc + WIDTH'(1);

    pc_return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_plus1),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    // Next-state and next-PC source selection.
    always_comb begin
        w_state_next = r_state;
        w_sel        = SEL_HOLD;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_ovf        = 1'b0;
        w_unf        = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.stall) begin
                    w_sel = SEL_HOLD;
                end else if (bus.halt_req) begin
                    // The redirect decided this cycle is dropped; pc holds.
                    w_state_next = ST_HALTED;
                end else if (bus.ret) begin
                    if (w_ras_empty) begin
                        w_sel = SEL_SEQ;
                        w_unf = 1'b1;
                    end else begin
                        w_sel = SEL_RET;
                        w_pop = 1'b1;
                    end
                end else if (bus.call) begin
                    w_sel  = SEL_CALL;
                    w_push = 1'b1;
                    w_ovf  = w_ras_full;
                end else if (bus.jump) begin
                    w_sel = SEL_JUMP;
                end else if (bus.branch_taken) begin
                    w_sel = SEL_BRANCH;
                end else begin
                    w_sel = SEL_SEQ;
                end
            end
            ST_HALTED: begin
                if (bus.resume && !bus.stall) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            SEL_SEQ:    w_pc_next = w_pc_plus1;
            SEL_BRANCH: w_pc_next = bus.branch_target;
            SEL_JUMP:   w_pc_next = bus.jump_target;
            SEL_CALL:   w_pc_next = bus.jump_target;
            SEL_RET:    w_pc_next = w_ras_top;
            default:    w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end
    end

    assign bus.pc            = r_pc;
    assign bus.pc_plus1      = w_pc_plus1;
    assign bus.fetch_valid   = (r_state == ST_RUN);
    assign bus.halted        = (r_state == ST_HALTED);
    assign bus.ras_overflow  = r_ovf;
    assign bus.ras_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer. A queue-based reference
//             model predicts every output after each clock edge; directed
//             scenarios are followed by randomized control traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    localparam int          WIDTH  = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0010;
    localparam int          DEPTH  = 4;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

    pc_sequencer #(
        .WIDTH     (WIDTH),
        .RESET_PC  (RST_PC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        m_ovf;
    logic        m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall         = 1'b0;
        bus.halt_req      = 1'b0;
        bus.resume        = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.call          = 1'b0;
        bus.jump_target   = '0;
        bus.ret           = 1'b0;
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_edge();
        if (reset) begin
            m_mode = M_BOOT;
            m_pc   = RST_PC;
            m_ras.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            return;
        end
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (bus.resume && !bus.stall) m_mode = M_RUN;
        end else begin
            if (bus.stall) begin
                // nothing changes
            end else if (bus.halt_req) begin
                m_mode = M_HALT;
            end else if (bus.ret) begin
                if (m_ras.size() == 0) begin
                    m_pc  = m_pc + 32'd1;
                    m_unf = 1'b1;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (bus.call) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_pc + 32'd1);
                m_pc = bus.jump_target;
            end else if (bus.jump) begin
                m_pc = bus.jump_target;
            end else if (bus.branch_taken) begin
                m_pc = bus.branch_target;
            end else begin
                m_pc = m_pc + 32'd1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, " pc"},          bus.pc,                  m_pc);
        chk({tag, " pc_plus1"},    bus.pc_plus1,            m_pc + 32'd1);
        chk({tag, " fetch_valid"}, 32'(bus.fetch_valid),    32'(m_mode == M_RUN));
        chk({tag, " halted"},      32'(bus.halted),         32'(m_mode == M_HALT));
        chk({tag, " ovf"},         32'(bus.ras_overflow),   32'(m_ovf));
        chk({tag, " unf"},         32'(bus.ras_underflow),  32'(m_unf));
    endtask

    initial begin
        m_mode = M_BOOT;
        m_pc   = RST_PC;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        idle();
        reset = 1'b1;

        // Reset, BOOT, then sequential fetch from RESET_PC
        cycle("reset");
        chk("reset pc const", bus.pc, 32'h10);
        chk("reset fv const", 32'(bus.fetch_valid), 32'd0);
        reset = 1'b0;
        cycle("boot");
        chk("first fetch pc", bus.pc, 32'h10);
        chk("first fetch fv", 32'(bus.fetch_valid), 32'd1);
        cycle("seq1");
        cycle("seq2");
        chk("seq2 pc const", bus.pc, 32'h12);

        // Jump beats branch; then a lone branch
        bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
        bus.jump = 1'b1; bus.jump_target = 32'h80;
        cycle("jmp_over_br");
        chk("jmp_over_br const", bus.pc, 32'h80);
        idle(); bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
        cycle("branch");
        chk("branch const", bus.pc, 32'h40);

        // call / ret round trip
        idle(); bus.jump = 1'b1; bus.jump_target = 32'h05;
        cycle("to5");
        idle(); bus.call = 1'b1; bus.jump_target = 32'h100;
        cycle("call");
        idle();
        for (int i = 0; i < 3; i++) cycle("callseq");
        bus.ret = 1'b1;
        cycle("ret");
        chk("ret const", bus.pc, 32'h06);

        // Five nested calls (last overflows), five returns (last underflows)
        for (int i = 0; i < 5; i++) begin
            idle(); bus.call = 1'b1; bus.jump_target = 32'h200 + 32'(i) * 32'h100;
            cycle("nest_call");
        end
        chk("overflow const", 32'(bus.ras_overflow), 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle(); bus.ret = 1'b1;
            cycle("nest_ret");
        end
        chk("underflow const", 32'(bus.ras_underflow), 32'd1);
        chk("underflow pc const", bus.pc, 32'h202);

        // Halt, stall+resume stays halted, resume
        idle(); bus.jump = 1'b1; bus.jump_target = 32'h20;
        cycle("to20");
        idle(); bus.halt_req = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h99;
        cycle("halt");
        chk("halt pc const", bus.pc, 32'h20);
        idle(); bus.stall = 1'b1; bus.resume = 1'b1;
        cycle("stall_resume");
        chk("stall_resume halted", 32'(bus.halted), 32'd1);
        idle(); bus.resume = 1'b1;
        cycle("resume");
        idle();
        cycle("after_resume");
        chk("after_resume const", bus.pc, 32'h21);

        // Wrap of the all-ones PC
        bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFF;
        cycle("to_max");
        idle();
        cycle("wrap");
        chk("wrap const", bus.pc, 32'h0);

        // Reset during stall with two stacked entries
        bus.call = 1'b1; bus.jump_target = 32'h300;
        cycle("rc1");
        bus.jump_target = 32'h400;
        cycle("rc2");
        idle(); bus.stall = 1'b1; reset = 1'b1;
        cycle("reset_stall");
        reset = 1'b0; idle();
        cycle("reboot");
        bus.ret = 1'b1;
        cycle("ret_after_reset");
        chk("ret_after_reset unf", 32'(bus.ras_underflow), 32'd1);

        // Randomized control traffic
        for (int n = 0; n < 400; n++) begin
            reset             = ($urandom_range(0, 59) == 0);
            bus.stall         = ($urandom_range(0, 7) == 0);
            bus.halt_req      = ($urandom_range(0, 15) == 0);
            bus.resume        = ($urandom_range(0, 3) == 0);
            bus.ret           = ($urandom_range(0, 5) == 0);
            bus.call          = ($urandom_range(0, 4) == 0);
            bus.jump          = ($urandom_range(0, 7) == 0);
            bus.branch_taken  = ($urandom_range(0, 3) == 0);
            bus.branch_target = $urandom();
            bus.jump_target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
